tile_render_scheduler: RTL

Sequences the 8x8 sprite drawer to render the Sokoban board. It walks the tile map (20x15 tiles covering 160x120) and issues one draw command per tile, waiting for the drawer to finish before issuing the next. It arbitrates between two requesters for the single drawer: a full-board redraw from the game FSM, and single-tile updates from move logic (player/box moves). It sits between the game logic, the tile map RAM and the sprite drawer.

---
 rtl/tile_render_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tile_render_scheduler.sv
// Tile render scheduler: walks the tile map and feeds one 8x8 sprite draw per tile,
// arbitrating between full-board sweeps and single-tile updates for the one drawer.
module tile_render_scheduler #(
  parameter int GRID_W     = 20,
  parameter int GRID_H     = 15,
  parameter int TILE_SHIFT = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_full_redraw,
  input  logic       i_upd_valid,
  output logic       o_upd_ready,
  input  logic [4:0] i_upd_col,
  input  logic [3:0] i_upd_row,
  output logic       o_upd_err,
  output logic [8:0] o_map_addr,
  input  logic [2:0] i_map_data,
  output logic       o_draw_go,
  output logic [7:0] o_draw_x,
  output logic [6:0] o_draw_y,
  output logic [2:0] o_draw_sprite,
  input  logic       i_draw_done,
  output logic       o_busy,
  output logic       o_frame_done
);

  // state     | meaning
  // S_IDLE    | waiting for a redraw or a single-tile update
  // S_FETCH   | map address presented to the tile RAM
  // S_WAIT    | RAM data valid, capture sprite id and pixel anchor
  // S_ISSUE   | draw_go pulse to the drawer
  // S_WAIT_DONE | waiting for draw_done from the drawer
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_WAIT_DONE
  } state_t;

  localparam logic [4:0] LP_COL_MAX = 5'(GRID_W - 1);
  localparam logic [3:0] LP_ROW_MAX = 4'(GRID_H - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_pending;
  logic       r_sweep;
  logic [4:0] r_col;
  logic [3:0] r_row;
  logic [7:0] r_draw_x;
  logic [6:0] r_draw_y;
  logic [2:0] r_draw_sprite;
  logic       r_upd_err;
  logic       r_frame_done;

  logic w_sweep_start;
  logic w_upd_take;
  logic w_upd_bad;
  logic w_last_tile;
  logic w_tile_done;

  assign w_sweep_start = (r_state == S_IDLE) && (r_pending || i_full_redraw);
  assign w_upd_take    = (r_state == S_IDLE) && !w_sweep_start && i_upd_valid;
  assign w_upd_bad     = (i_upd_col > LP_COL_MAX) || (i_upd_row > LP_ROW_MAX);
  assign w_last_tile   = (r_col == LP_COL_MAX) && (r_row == LP_ROW_MAX);
  assign w_tile_done   = (r_state == S_WAIT_DONE) && i_draw_done;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_pending     <= 1'b0;
      r_sweep       <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r_draw_x      <= '0;
      r_draw_y      <= '0;
      r_draw_sprite <= '0;
      r_upd_err     <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_upd_err    <= w_upd_take && w_upd_bad;
      r_frame_done <= w_tile_done && r_sweep && w_last_tile;

      // A request arriving while a sweep starts is absorbed by that sweep.
      if (w_sweep_start)
        r_pending <= 1'b0;
      else if (i_full_redraw)
        r_pending <= 1'b1;

      if (w_sweep_start) begin
        r_sweep <= 1'b1;
        r_col   <= '0;
        r_row   <= '0;
      end else if (w_upd_take && !w_upd_bad) begin
        r_sweep <= 1'b0;
        r_col   <= i_upd_col;
        r_row   <= i_upd_row;
      end else if (w_tile_done && r_sweep && !w_last_tile) begin
        if (r_col == LP_COL_MAX) begin
          r_col <= '0;
          r_row <= r_row + 4'd1;
        end else begin
          r_col <= r_col + 5'd1;
        end
      end

      if (r_state == S_WAIT) begin
        r_draw_sprite <= i_map_data;
        r_draw_x      <= 8'(r_col) << TILE_SHIFT;
        r_draw_y      <= 7'(r_row) << TILE_SHIFT;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    o_upd_ready   = 1'b0;
    o_draw_go     = 1'b0;
    o_busy        = (r_state != S_IDLE);
    o_map_addr    = 9'(r_row) * 9'(GRID_W) + 9'(r_col);
    o_draw_x      = r_draw_x;
    o_draw_y      = r_draw_y;
    o_draw_sprite = r_draw_sprite;
    o_upd_err     = r_upd_err;
    o_frame_done  = r_frame_done;
    case (r_state)
      S_IDLE: begin
        o_upd_ready = !r_pending && !i_full_redraw;
        if (w_sweep_start || (w_upd_take && !w_upd_bad))
          w_next = S_FETCH;
      end
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  w_next = S_ISSUE;
      S_ISSUE: begin
        // Gated so a tile abandoned by reset never fires the drawer.
        o_draw_go = resetn;
        w_next    = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_draw_done)
          w_next = (!r_sweep || w_last_tile) ? S_IDLE : S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
